// File: rtl/demux_88_reg_pkg.sv
// Shared types and constants for the 8-way registered bus demux.
package demux_88_reg_pkg;

  localparam int unsigned IdxW    = 3;
  localparam int unsigned NumRegs = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } state_e;

  function automatic logic [NumRegs-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NumRegs-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_88_reg_if.sv
// Input-side bus of the demux: data, index, valid/ready handshake and burst/abort/clear controls.
interface demux_88_reg_if #(
  parameter int unsigned WIDTH = 8
);
  import demux_88_reg_pkg::*;

  logic [IdxW-1:0]  sel;
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic             burst_start;
  logic [IdxW-1:0]  burst_len;
  logic             abort;
  logic             clear;

  modport master (
    output sel, d, in_valid, burst_start, burst_len, abort, clear,
    input  in_ready
  );

  modport slave (
    input  sel, d, in_valid, burst_start, burst_len, abort, clear,
    output in_ready
  );

endinterface

// File: rtl/demux_88_reg_reg_en.sv
// WIDTH-bit register with async reset, synchronous clear (priority) and write enable.
module demux_88_reg_reg_en #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux_88_reg.sv
// Steers one bus value into one of eight registered outputs; single writes or wrapping bursts.
module demux_88_reg
  import demux_88_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  demux_88_reg_if.slave     bus,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  e,
  output logic [WIDTH-1:0]  f,
  output logic [WIDTH-1:0]  g,
  output logic [WIDTH-1:0]  h,
  output logic [NumRegs-1:0] wr_strobe,
  output logic              busy,
  output logic              done
);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [3:0]           rem_q, rem_d;
  logic [NumRegs-1:0]   strobe_d;
  logic                 done_d;
  logic                 ready;
  logic                 wr_en;
  logic [IdxW-1:0]      wr_idx;
  logic [NumRegs-1:0]   reg_en;
  logic [WIDTH-1:0]     q_arr [NumRegs];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    ready    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = bus.sel;
    unique case (state_q)
      StIdle: begin
        ready = ~bus.burst_start;
        if (bus.burst_start) begin
          ptr_d   = bus.sel;
          rem_d   = {1'b0, bus.burst_len} + 4'd1;
          state_d = StBurst;
        end else if (bus.in_valid) begin
          wr_en = 1'b1;
        end
      end
      StBurst: begin
        ready = ~bus.abort;
        if (bus.abort) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (bus.in_valid) begin
          wr_en  = 1'b1;
          wr_idx = ptr_q;
          ptr_d  = ptr_q + 3'd1;
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Clear wins over the data write but leaves burst bookkeeping untouched.
    strobe_d = bus.clear ? '1 : (wr_en ? onehot(wr_idx) : '0);
    reg_en   = wr_en ? onehot(wr_idx) : '0;
  end

  assign bus.in_ready = ready;
  assign busy         = (state_q == StBurst);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      rem_q     <= '0;
      wr_strobe <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      wr_strobe <= strobe_d;
      done      <= done_d;
    end
  end

  for (genvar i = 0; i < NumRegs; i++) begin : g_regs
    demux_88_reg_reg_en #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clear),
      .en    (reg_en[i]),
      .d     (bus.d),
      .q     (q_arr[i])
    );
  end

  assign a = q_arr[0];
  assign b = q_arr[1];
  assign c = q_arr[2];
  assign d = q_arr[3];
  assign e = q_arr[4];
  assign f = q_arr[5];
  assign g = q_arr[6];
  assign h = q_arr[7];

endmodule
